ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
Data-phase response multiplexer for the AHB bus, the return-path counterpart of the address decoder. It registers the decoder's slave selects during the address phase. It then routes HRDATA/HREADY/HRESP from the selected slave back to the master in the data phase. It contains the bus default slave, which answers unmapped accesses with a two-cycle ERROR.

Parameters:
DATA_BITS, `AHB_DATA_BITS (32), width of read data.
DEFAULT_RDATA, 32'h0000_0000, HRDATA driven while the default slave owns the data phase.

Ports:
HCLK  input  1  bus clock; all state on rising edge.
HRESET  input  1  synchronous, active-high reset.
HSELDefault  input  1  decoder select, default slave.
HSEL_S1..HSEL_S5  input  1 each  decoder selects, slaves 1-5.
HTRANS  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
HRDATA_S1..HRDATA_S5  input  DATA_BITS each  slave read data.
HREADY_S1..HREADY_S5  input  1 each  slave ready outputs.
HRESP_S1..HRESP_S5  input  2 each  slave responses (00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT).
HREADY  output  1  global ready to master and all slaves.
HRESP  output  2  muxed response.
HRDATA  output  DATA_BITS  muxed read data.

Behaviour:
- Interface is fixed: one clock, HCLK. Reset is HRESET, synchronous and active-high.
- Address-phase capture:
  - On a rising HCLK edge where HREADY=1, a one-hot data-phase select register sel_q[5:0] = {DEF,S5..S1} loads from the HSEL inputs.
  - While HREADY=0, sel_q holds.
- Select priority:
  - Any HSEL_Sx=1 overrides HSELDefault. HSELDefault can be high together with S3/S4/S5.
  - If several HSEL_Sx are high, S1>S2>S3>S4>S5.
  - No select high at all means the default slave is selected.
- Transfer type capture: trans_q latches on the same edge as sel_q. It records whether HTRANS was NONSEQ/SEQ (active) or IDLE/BUSY.
- Output mux (combinational from sel_q and the default FSM):
  - When sel_q=Sx: HRDATA=HRDATA_Sx, HREADY=HREADY_Sx, HRESP=HRESP_Sx.
  - When sel_q=DEF: HRDATA=DEFAULT_RDATA, with HREADY/HRESP driven by the default FSM.
- Default slave FSM, states DS_OK, DS_ERR1, DS_ERR2:
  - DS_OK: HREADY=1, HRESP=OKAY. On a capture edge with DEF selected and HTRANS active, go to DS_ERR1. Otherwise stay.
  - DS_ERR1: HREADY=0, HRESP=ERROR. Unconditionally go to DS_ERR2 next cycle.
  - DS_ERR2: HREADY=1, HRESP=ERROR. This is a capture edge, so the next address is sampled. If that address is again DEF and active, go to DS_ERR1. Otherwise go to DS_OK.
  - An IDLE or BUSY transfer to DEF gets a zero-wait OKAY (stays in DS_OK).
- FSM advancement: the FSM advances only while HREADY output=1 or it is in DS_ERR1. A wait-stated real slave therefore cannot corrupt it.
- Latency:
  - Real-slave responses pass through with zero added cycles.
  - A default-slave error is exactly 2 data-phase cycles.
- Reset:
  - sel_q=DEF, trans_q=inactive, FSM=DS_OK.
  - Outputs are therefore HREADY=1, HRESP=00, HRDATA=DEFAULT_RDATA.
  - Reset asserted mid-error (DS_ERR1 or DS_ERR2) returns to DS_OK on the next edge. No residual ERROR cycle.
- Back-to-back: a slave switch on consecutive cycles is legal. The data phase of transfer N uses the select of N while the address of N+1 is captured.

Decomposition:
- Package ahb_mux_pkg holds:
  - HRESP encodings (RESP_OKAY, RESP_ERROR, RESP_RETRY, RESP_SPLIT).
  - HTRANS encodings (TRANS_IDLE, TRANS_BUSY, TRANS_NONSEQ, TRANS_SEQ).
  - A ds_state_e enum.
  - Slave-index constants for sel_q bit positions.
- One sub-module is natural: ahb_default_slave, holding the 3-state FSM. Its ports are HCLK, HRESET, sel, active, hready_in, HREADYOUT, HRESP.
- The mux and select register stay in ahb_resp_mux.

Test Plan:
- Reset: hold HRESET 2 cycles -> HREADY=1, HRESP=00, HRDATA=0 for the whole reset.
- S1 read, zero-wait: HSEL_S1=1, NONSEQ, then HRDATA_S1=32'hDEAD_BEEF, HREADY_S1=1 -> HRDATA=32'hDEAD_BEEF one cycle after address, HRESP=00.
- S2 wait states: HREADY_S2 low 3 cycles while the next address is S3 -> HREADY=0 for 3 cycles, sel_q stays S2, S3 is captured only on the HREADY=1 edge.
- Unmapped NONSEQ: HSELDefault only, HTRANS=10 -> HREADY=0/HRESP=01, then HREADY=1/HRESP=01, then DS_OK.
- Overlap and IDLE: HSELDefault=1 with HSEL_S4=1 routes to S4 data. HSELDefault alone with HTRANS=00 -> zero-wait OKAY.
- Reset in DS_ERR1 -> next cycle HREADY=1, HRESP=00, sel_q=DEF. Back-to-back unmapped NONSEQ -> ERR1, ERR2, ERR1, ERR2.

Source files
------------

// File: rtl/ahb_mux_pkg.sv
// Shared encodings for the AHB data-phase response multiplexer.
// Response/transfer codes, select bit positions, default-slave states.
package ahb_mux_pkg;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;
    localparam logic [1:0] RESP_RETRY = 2'b10;
    localparam logic [1:0] RESP_SPLIT = 2'b11;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam int IDX_S1  = 0;
    localparam int IDX_S2  = 1;
    localparam int IDX_S3  = 2;
    localparam int IDX_S4  = 3;
    localparam int IDX_S5  = 4;
    localparam int IDX_DEF = 5;
    localparam int NUM_SEL = 6;

    localparam logic [NUM_SEL-1:0] SEL_DEF = 6'b10_0000;

    typedef enum logic [1:0] {
        DS_OK   = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_e;

    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == TRANS_NONSEQ) || (trans == TRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Bus default slave: zero-wait OKAY for idle/busy, two-cycle ERROR
// for any active transfer that reaches an unmapped address.
module ahb_default_slave
    import ahb_mux_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       sel,
    input  logic       active,
    input  logic       hready_in,
    output logic       HREADYOUT,
    output logic [1:0] HRESP
);

    ds_state_e state_q;
    logic      go_err;

    assign go_err = sel && active;

    // Frozen while a wait-stated real slave holds the bus; ERR1 is our own stall.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= DS_OK;
            HREADYOUT <= 1'b1;
            HRESP     <= RESP_OKAY;
        end else if (hready_in || state_q == DS_ERR1) begin
            unique case (state_q)
                DS_OK: begin
                    if (go_err) begin
                        state_q   <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= RESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state_q   <= DS_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_ERROR;
                end
                DS_ERR2: begin
                    if (go_err) begin
                        state_q   <= DS_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= RESP_ERROR;
                    end else begin
                        state_q   <= DS_OK;
                        HREADYOUT <= 1'b1;
                        HRESP     <= RESP_OKAY;
                    end
                end
                default: begin
                    state_q   <= DS_OK;
                    HREADYOUT <= 1'b1;
                    HRESP     <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB data-phase response mux: registers decoder selects in the address
// phase and returns the selected slave's HRDATA/HREADY/HRESP.
module ahb_resp_mux
    import ahb_mux_pkg::*;
#(
    parameter int                   DATA_BITS     = 32,
    parameter logic [DATA_BITS-1:0] DEFAULT_RDATA = '0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSELDefault,
    input  logic                 HSEL_S1,
    input  logic                 HSEL_S2,
    input  logic                 HSEL_S3,
    input  logic                 HSEL_S4,
    input  logic                 HSEL_S5,
    input  logic [1:0]           HTRANS,
    input  logic [DATA_BITS-1:0] HRDATA_S1,
    input  logic [DATA_BITS-1:0] HRDATA_S2,
    input  logic [DATA_BITS-1:0] HRDATA_S3,
    input  logic [DATA_BITS-1:0] HRDATA_S4,
    input  logic [DATA_BITS-1:0] HRDATA_S5,
    input  logic                 HREADY_S1,
    input  logic                 HREADY_S2,
    input  logic                 HREADY_S3,
    input  logic                 HREADY_S4,
    input  logic                 HREADY_S5,
    input  logic [1:0]           HRESP_S1,
    input  logic [1:0]           HRESP_S2,
    input  logic [1:0]           HRESP_S3,
    input  logic [1:0]           HRESP_S4,
    input  logic [1:0]           HRESP_S5,
    output logic                 HREADY,
    output logic [1:0]           HRESP,
    output logic [DATA_BITS-1:0] HRDATA
);

    logic [NUM_SEL-1:0] sel_d;
    logic [NUM_SEL-1:0] sel_q;
    logic               trans_q;
    logic               active;
    logic               ds_hready;
    logic [1:0]         ds_resp;

    assign active = trans_active(HTRANS);

    // Real slaves win over the default select; lowest index wins among them.
    always_comb begin
        sel_d = '0;
        if (HSEL_S1)      sel_d[IDX_S1]  = 1'b1;
        else if (HSEL_S2) sel_d[IDX_S2]  = 1'b1;
        else if (HSEL_S3) sel_d[IDX_S3]  = 1'b1;
        else if (HSEL_S4) sel_d[IDX_S4]  = 1'b1;
        else if (HSEL_S5) sel_d[IDX_S5]  = 1'b1;
        else              sel_d[IDX_DEF] = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q   <= SEL_DEF;
            trans_q <= 1'b0;
        end else if (HREADY) begin
            sel_q   <= sel_d;
            trans_q <= active;
        end
    end

    ahb_default_slave u_default (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .sel       (sel_d[IDX_DEF]),
        .active    (active),
        .hready_in (HREADY),
        .HREADYOUT (ds_hready),
        .HRESP     (ds_resp)
    );

    always_comb begin
        HRDATA = DEFAULT_RDATA;
        HREADY = ds_hready;
        HRESP  = ds_resp;
        unique case (1'b1)
            sel_q[IDX_S1]: begin
                HRDATA = HRDATA_S1;
                HREADY = HREADY_S1;
                HRESP  = HRESP_S1;
            end
            sel_q[IDX_S2]: begin
                HRDATA = HRDATA_S2;
                HREADY = HREADY_S2;
                HRESP  = HRESP_S2;
            end
            sel_q[IDX_S3]: begin
                HRDATA = HRDATA_S3;
                HREADY = HREADY_S3;
                HRESP  = HRESP_S3;
            end
            sel_q[IDX_S4]: begin
                HRDATA = HRDATA_S4;
                HREADY = HREADY_S4;
                HRESP  = HRESP_S4;
            end
            sel_q[IDX_S5]: begin
                HRDATA = HRDATA_S5;
                HREADY = HREADY_S5;
                HRESP  = HRESP_S5;
            end
            default: begin
            end
        endcase
    end

    // An idle/busy data phase owned by the default slave never stalls.
    a_idle_def_ready : assert property (
        @(posedge HCLK) disable iff (HRESET)
        (sel_q[IDX_DEF] && !trans_q) |-> HREADY
    );

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed self-checking bench for ahb_resp_mux.
// Compares {HREADY,HRESP,HRDATA} against hand-computed values per cycle.
module tb_ahb_resp_mux;

    logic        HCLK;
    logic        HRESET;
    logic        HSELDefault;
    logic        HSEL_S1, HSEL_S2, HSEL_S3, HSEL_S4, HSEL_S5;
    logic [1:0]  HTRANS;
    logic [31:0] HRDATA_S1, HRDATA_S2, HRDATA_S3, HRDATA_S4, HRDATA_S5;
    logic        HREADY_S1, HREADY_S2, HREADY_S3, HREADY_S4, HREADY_S5;
    logic [1:0]  HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4, HRESP_S5;
    logic        HREADY;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;

    int n_cmp = 0;
    int n_bad = 0;

    ahb_resp_mux #(
        .DATA_BITS     (32),
        .DEFAULT_RDATA (32'h0000_0000)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSELDefault (HSELDefault),
        .HSEL_S1     (HSEL_S1),
        .HSEL_S2     (HSEL_S2),
        .HSEL_S3     (HSEL_S3),
        .HSEL_S4     (HSEL_S4),
        .HSEL_S5     (HSEL_S5),
        .HTRANS      (HTRANS),
        .HRDATA_S1   (HRDATA_S1),
        .HRDATA_S2   (HRDATA_S2),
        .HRDATA_S3   (HRDATA_S3),
        .HRDATA_S4   (HRDATA_S4),
        .HRDATA_S5   (HRDATA_S5),
        .HREADY_S1   (HREADY_S1),
        .HREADY_S2   (HREADY_S2),
        .HREADY_S3   (HREADY_S3),
        .HREADY_S4   (HREADY_S4),
        .HREADY_S5   (HREADY_S5),
        .HRESP_S1    (HRESP_S1),
        .HRESP_S2    (HRESP_S2),
        .HRESP_S3    (HRESP_S3),
        .HRESP_S4    (HRESP_S4),
        .HRESP_S5    (HRESP_S5),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HRDATA      (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus();
        HSELDefault = 1'b0;
        HSEL_S1 = 1'b0;
        HSEL_S2 = 1'b0;
        HSEL_S3 = 1'b0;
        HSEL_S4 = 1'b0;
        HSEL_S5 = 1'b0;
        HTRANS  = 2'b00;
    endtask

    task automatic test_reset();
        logic [34:0] obs, exp;
        HRESET = 1'b1;
        idle_bus();
        HSEL_S1 = 1'b1;
        HTRANS  = 2'b10;
        HRDATA_S1 = 32'h5A5A_0001;
        HRDATA_S2 = 32'h5A5A_0002;
        HRDATA_S3 = 32'h5A5A_0003;
        HRDATA_S4 = 32'h5A5A_0004;
        HRDATA_S5 = 32'h5A5A_0005;
        {HREADY_S1, HREADY_S2, HREADY_S3, HREADY_S4, HREADY_S5} = 5'b11111;
        {HRESP_S1, HRESP_S2, HRESP_S3, HRESP_S4, HRESP_S5} = 10'b0;
        exp = {1'b1, 2'b00, 32'h0000_0000};
        for (int i = 0; i < 2; i++) begin
            tick();
            #3;
            obs = {HREADY, HRESP, HRDATA};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_%0d: got %h want %h", i, obs, exp);
            end
        end
        idle_bus();
        HRESET = 1'b0;
    endtask

    task automatic test_s1_read();
        logic [34:0] obs, exp;
        idle_bus();
        HSEL_S1 = 1'b1;
        HTRANS  = 2'b10;
        tick();
        idle_bus();
        HRDATA_S1 = 32'hDEAD_BEEF;
        HRDATA_S2 = 32'h1111_2222;
        HREADY_S1 = 1'b1;
        HRESP_S1  = 2'b00;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'hDEAD_BEEF};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL s1_read: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_s2_wait();
        logic [34:0] obs, exp;
        idle_bus();
        HSEL_S2 = 1'b1;
        HTRANS  = 2'b10;
        tick();
        idle_bus();
        HSEL_S3 = 1'b1;
        HTRANS  = 2'b10;
        HREADY_S2 = 1'b0;
        HRDATA_S2 = 32'hC0FF_EE02;
        HRDATA_S3 = 32'h3333_0003;
        exp = {1'b0, 2'b00, 32'hC0FF_EE02};
        for (int i = 0; i < 3; i++) begin
            #3;
            obs = {HREADY, HRESP, HRDATA};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL s2_wait_%0d: got %h want %h", i, obs, exp);
            end
            tick();
        end
        HREADY_S2 = 1'b1;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'hC0FF_EE02};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL s2_done: got %h want %h", obs, exp);
        end
        tick();
        idle_bus();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'h3333_0003};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL s3_after_wait: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_unmapped();
        logic [34:0] obs, exp;
        idle_bus();
        HSELDefault = 1'b1;
        HTRANS = 2'b10;
        tick();
        HTRANS = 2'b00;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b0, 2'b01, 32'h0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL unmapped_err1: got %h want %h", obs, exp);
        end
        tick();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b01, 32'h0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL unmapped_err2: got %h want %h", obs, exp);
        end
        tick();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'h0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL unmapped_ok: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_overlap_idle();
        logic [34:0] obs, exp;
        idle_bus();
        HSELDefault = 1'b1;
        HSEL_S4 = 1'b1;
        HTRANS  = 2'b10;
        tick();
        idle_bus();
        HSELDefault = 1'b1;
        HRDATA_S4 = 32'h4444_ABCD;
        HRESP_S4  = 2'b10;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b10, 32'h4444_ABCD};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL overlap_s4: got %h want %h", obs, exp);
        end
        tick();
        HRESP_S4 = 2'b00;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'h0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL idle_def: got %h want %h", obs, exp);
        end
        HTRANS = 2'b01;
        tick();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL busy_def: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_priority();
        logic [34:0] obs, exp;
        idle_bus();
        HSELDefault = 1'b1;
        HSEL_S2 = 1'b1;
        HSEL_S5 = 1'b1;
        HTRANS  = 2'b11;
        tick();
        idle_bus();
        HRDATA_S2 = 32'h2222_0002;
        HRDATA_S5 = 32'h5555_0005;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'h2222_0002};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL prio_s2_s5: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_reset_in_err();
        logic [34:0] obs, exp;
        idle_bus();
        HSELDefault = 1'b1;
        HTRANS = 2'b10;
        tick();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b0, 2'b01, 32'h0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rst_err_enter: got %h want %h", obs, exp);
        end
        HRESET = 1'b1;
        idle_bus();
        HSEL_S1 = 1'b1;
        HTRANS  = 2'b10;
        tick();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'h0};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rst_err_clear: got %h want %h", obs, exp);
        end
        HRESET = 1'b0;
        idle_bus();
        tick();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL rst_err_after: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] obs, exp;
        idle_bus();
        HSELDefault = 1'b1;
        HTRANS = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            #3;
            obs = {HREADY, HRESP, HRDATA};
            exp = {(i % 2 == 1), 2'b01, 32'h0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b_err_%0d: got %h want %h", i, obs, exp);
            end
        end
        idle_bus();
        HSEL_S1 = 1'b1;
        HTRANS  = 2'b10;
        HRDATA_S1 = 32'hA1A1_0001;
        HRDATA_S5 = 32'hB5B5_0005;
        tick();
        idle_bus();
        HSEL_S5 = 1'b1;
        HTRANS  = 2'b11;
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'hA1A1_0001};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL b2b_s1: got %h want %h", obs, exp);
        end
        tick();
        idle_bus();
        #3;
        obs = {HREADY, HRESP, HRDATA};
        exp = {1'b1, 2'b00, 32'hB5B5_0005};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL b2b_s5: got %h want %h", obs, exp);
        end
    endtask

    initial begin
        test_reset();
        test_s1_read();
        test_s2_wait();
        test_unmapped();
        test_overlap_idle();
        test_priority();
        test_reset_in_err();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
